// File: rtl/text_overlay.sv
// text_overlay: renders a writable glyph string over the VGA pixel stream via an external 1-cycle font ROM
module text_overlay #(
    parameter int NUM_CHARS  = 8,
    parameter int SCALE_LOG2 = 3,
    parameter int ORIGIN_X   = 192,
    parameter int ORIGIN_Y   = 256,
    parameter int IDX_W      = 3
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [9:0]       pos_x,
    input  logic [9:0]       pos_y,
    input  logic             pix_valid,
    input  logic             char_we,
    input  logic [IDX_W-1:0] char_waddr,
    input  logic [6:0]       char_wdata,
    input  logic [2:0]       colour_in,
    input  logic             blink_en,
    input  logic             frame_tick,
    output logic [10:0]      rom_addr,
    input  logic [7:0]       rom_data,
    output logic             text_on,
    output logic [2:0]       text_colour,
    output logic             out_valid
);
    localparam int BOX_W = NUM_CHARS << (SCALE_LOG2 + 3);
    localparam int BOX_H = 16 << SCALE_LOG2;

    logic [10:0]      dx, dy;
    logic [9:0]       rx, ry;
    logic [IDX_W-1:0] idx;
    logic [2:0]       col, col1, col2;
    logic [3:0]       row;
    logic             in_box, box1, box2, v1, v2;
    logic [6:0]       char_buf [NUM_CHARS];
    logic [4:0]       blink_cnt;
    logic             blank, lit;

    // A borrow out of the 11-bit subtraction means the pixel lies left of / above the origin.
    assign dx     = {1'b0, pos_x} - 11'(ORIGIN_X);
    assign dy     = {1'b0, pos_y} - 11'(ORIGIN_Y);
    assign rx     = dx[9:0];
    assign ry     = dy[9:0];
    assign in_box = !dx[10] && ({22'd0, rx} < 32'(BOX_W)) && !dy[10] && ({22'd0, ry} < 32'(BOX_H));
    assign idx    = IDX_W'(rx >> (SCALE_LOG2 + 3));
    assign col    = rx[SCALE_LOG2+2:SCALE_LOG2];
    assign row    = ry[SCALE_LOG2+3:SCALE_LOG2];
    assign blank  = blink_en & blink_cnt[4];
    assign lit    = v2 & box2 & rom_data[3'd7 - col2] & ~blank;

    // Character buffer; a write lands at the edge so a same-cycle S1 read sees the old code.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_CHARS; i++) char_buf[i] <= 7'h20;
        end else if (char_we && (32'(char_waddr) < 32'(NUM_CHARS))) begin
            char_buf[char_waddr] <= char_wdata;
        end
    end

    // Frame counter for blink; keeps running even when blink is disabled.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) blink_cnt <= 5'd0;
        else if (frame_tick) blink_cnt <= blink_cnt + 5'd1;
    end

    // S1/S2: issue the ROM address for in-box pixels and carry column/box/valid alongside the ROM latency.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rom_addr <= 11'd0;
            col1     <= 3'd0;
            box1     <= 1'b0;
            v1       <= 1'b0;
            col2     <= 3'd0;
            box2     <= 1'b0;
            v2       <= 1'b0;
        end else begin
            if (pix_valid && in_box) rom_addr <= {char_buf[idx], row};
            col1 <= col;
            box1 <= in_box;
            v1   <= pix_valid;
            col2 <= col1;
            box2 <= box1;
            v2   <= v1;
        end
    end

    // S3: select the glyph bit, apply blink and colour.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            text_on     <= 1'b0;
            text_colour <= 3'd0;
            out_valid   <= 1'b0;
        end else begin
            text_on     <= lit;
            text_colour <= lit ? colour_in : 3'd0;
            out_valid   <= v2;
        end
    end
endmodule

// File: tb/tb_text_overlay.sv
// tb_text_overlay: directed checks of text_overlay geometry, latency, buffer hazard, blink and reset
module tb_text_overlay;
    localparam int N = 540;

    logic        clk = 1'b0;
    logic        resetn, pix_valid, char_we, blink_en, frame_tick;
    logic [9:0]  pos_x, pos_y;
    logic [2:0]  char_waddr, colour_in;
    logic [6:0]  char_wdata;
    logic [10:0] rom_addr, rom_addr_s;
    logic [7:0]  rom_data, rom_data_s;
    logic        text_on, text_on_s, out_valid, out_valid_s;
    logic [2:0]  text_colour, text_colour_s;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [6:0]  bufm [8];
    logic        exp_on [N];
    logic [2:0]  colh [N+3];
    logic [10:0] addr_q, addr_s_q;
    logic        on_q, on_s_q, ov_q, ov_early;
    logic [2:0]  col_q;

    text_overlay dut (
        .clk(clk), .resetn(resetn), .pos_x(pos_x), .pos_y(pos_y), .pix_valid(pix_valid),
        .char_we(char_we), .char_waddr(char_waddr), .char_wdata(char_wdata),
        .colour_in(colour_in), .blink_en(blink_en), .frame_tick(frame_tick),
        .rom_addr(rom_addr), .rom_data(rom_data), .text_on(text_on),
        .text_colour(text_colour), .out_valid(out_valid)
    );

    text_overlay #(.NUM_CHARS(8), .SCALE_LOG2(0), .ORIGIN_X(0), .ORIGIN_Y(0), .IDX_W(3)) dut_s (
        .clk(clk), .resetn(resetn), .pos_x(pos_x), .pos_y(pos_y), .pix_valid(pix_valid),
        .char_we(char_we), .char_waddr(char_waddr), .char_wdata(char_wdata),
        .colour_in(colour_in), .blink_en(blink_en), .frame_tick(frame_tick),
        .rom_addr(rom_addr_s), .rom_data(rom_data_s), .text_on(text_on_s),
        .text_colour(text_colour_s), .out_valid(out_valid_s)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] font(input logic [10:0] a);
        return a[7:0] ^ {a[10:4], 1'b1};
    endfunction

    always @(posedge clk) begin
        rom_data   <= font(rom_addr);
        rom_data_s <= font(rom_addr_s);
    end

    function automatic logic model_on(input int x, input int y);
        int rx, ry;
        logic [10:0] a;
        logic [7:0] d;
        rx = x - 192;
        ry = y - 256;
        if (rx < 0 || rx >= 512 || ry < 0 || ry >= 128) return 1'b0;
        a = {bufm[rx >> 6], 4'((ry >> 3) & 15)};
        d = font(a);
        return d[7 - ((rx >> 3) & 7)];
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic write_char(input logic [2:0] a, input logic [6:0] d);
        @(negedge clk);
        char_we = 1'b1; char_waddr = a; char_wdata = d;
        @(negedge clk);
        char_we = 1'b0;
        bufm[a] = d;
    endtask

    task automatic run_pixel(input logic [9:0] x, input logic [9:0] y);
        @(negedge clk);
        pos_x = x; pos_y = y; pix_valid = 1'b1;
        @(negedge clk);
        pix_valid = 1'b0; addr_q = rom_addr; addr_s_q = rom_addr_s;
        @(negedge clk);
        ov_early = out_valid;
        @(negedge clk);
        on_q = text_on; col_q = text_colour; ov_q = out_valid; on_s_q = text_on_s;
    endtask

    task automatic ticks(input int n);
        @(negedge clk);
        frame_tick = 1'b1;
        repeat (n) @(negedge clk);
        frame_tick = 1'b0;
    endtask

    initial begin
        resetn = 1'b0; pix_valid = 1'b0; char_we = 1'b0; blink_en = 1'b0; frame_tick = 1'b0;
        pos_x = '0; pos_y = '0; char_waddr = '0; char_wdata = '0; colour_in = 3'd5;
        for (int i = 0; i < 8; i++) bufm[i] = 7'h20;
        repeat (2) @(negedge clk);
        check("rst_text_on", text_on, 0);
        check("rst_colour", text_colour, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_rom_addr", rom_addr, 0);
        resetn = 1'b1;

        write_char(0, 7'h53);
        run_pixel(192, 256);
        check("lat_rom_addr", addr_q, 11'h530);
        check("lat_early_valid", ov_early, 0);
        check("lat_text_on", on_q, 1);
        check("lat_colour", col_q, 5);
        check("lat_out_valid", ov_q, 1);
        check("lat_scaled_dut_off", on_s_q, 0);

        write_char(7, 7'h5A);
        run_pixel(191, 256);
        check("x191_off", on_q, 0);
        check("x191_addr_hold", addr_q, 11'h530);
        check("x191_valid", ov_q, 1);
        run_pixel(704, 256);
        check("x704_off", on_q, 0);
        run_pixel(192, 255);
        check("y255_off", on_q, 0);
        run_pixel(192, 384);
        check("y384_off", on_q, 0);
        run_pixel(703, 383);
        check("corner_addr", addr_q, 11'h5AF);
        check("corner_on", on_q, 0);

        write_char(1, 7'h4C);
        run_pixel(9, 0);
        check("scale0_addr", addr_s_q, 11'h4C0);
        check("scale0_on", on_s_q, 1);
        run_pixel(64, 0);
        check("scale0_x64_off", on_s_q, 0);
        check("scale0_x64_hold", addr_s_q, 11'h4C0);

        @(negedge clk);
        char_we = 1'b1; char_waddr = 3'd2; char_wdata = 7'h4C; pos_x = 344; pos_y = 256; pix_valid = 1'b1;
        @(negedge clk);
        char_we = 1'b0;
        check("hazard_old_addr", rom_addr, 11'h200);
        @(negedge clk);
        pix_valid = 1'b0;
        check("hazard_new_addr", rom_addr, 11'h4C0);
        @(negedge clk);
        check("hazard_old_on", text_on, 0);
        @(negedge clk);
        check("hazard_new_on", text_on, 1);
        bufm[2] = 7'h4C;

        for (int j = 0; j < N + 3; j++) begin
            @(negedge clk);
            if (j >= 3) begin
                check("stream_on", text_on, exp_on[j-3]);
                check("stream_colour", text_colour, exp_on[j-3] ? colh[j-1] : 3'd0);
                check("stream_valid", out_valid, 1);
            end
            colour_in = 3'(j * 5);
            colh[j] = colour_in;
            if (j < N) begin
                pos_x = 10'(180 + j); pos_y = 10'd296; pix_valid = 1'b1;
                exp_on[j] = model_on(180 + j, 296);
            end else begin
                pix_valid = 1'b0;
            end
        end
        colour_in = 3'd5;

        blink_en = 1'b1;
        run_pixel(192, 256);
        check("blink_cnt0_on", on_q, 1);
        ticks(16);
        run_pixel(192, 256);
        check("blink_cnt16_off", on_q, 0);
        check("blink_cnt16_colour", col_q, 0);
        check("blink_cnt16_valid", ov_q, 1);
        blink_en = 1'b0;
        run_pixel(192, 256);
        check("blink_disabled_on", on_q, 1);
        blink_en = 1'b1;
        ticks(15);
        run_pixel(192, 256);
        check("blink_cnt31_off", on_q, 0);
        ticks(1);
        run_pixel(192, 256);
        check("blink_wrap_on", on_q, 1);
        ticks(16);
        blink_en = 1'b0;

        @(negedge clk);
        pos_x = 192; pos_y = 256; pix_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("pre_rst_on", text_on, 1);
        check("pre_rst_colour", text_colour, 5);
        check("pre_rst_valid", out_valid, 1);
        #2 resetn = 1'b0;
        #1;
        check("async_rst_on", text_on, 0);
        check("async_rst_colour", text_colour, 0);
        check("async_rst_valid", out_valid, 0);
        check("async_rst_addr", rom_addr, 0);
        @(negedge clk);
        pix_valid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_no_valid", out_valid, 0);
        end
        blink_en = 1'b1;
        run_pixel(200, 256);
        check("post_rst_buf_space", addr_q, 11'h200);
        check("post_rst_cnt_clear", on_q, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
